mac_sequencer: RTL and testbench

Control FSM for the single-neuron MAC datapath (input/weight memories, 8-bit sign-magnitude multiplier, signed adder, 20-bit accumulator register, ReLU stage). It walks the memory select index across the N inputs of a neuron. It drives the accumulator clear and load strobes and raises the activation `ready` strobe. It repeats this for `NEURONS` consecutive neurons per `start`, so one shared MAC can evaluate a whole layer.

---
 rtl/mac_sequencer.sv | 102 ++++++++++
 tb/tb_mac_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mac_sequencer: walks input/neuron indices and strobes a shared MAC.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mac_sequencer #(
  parameter int N       = 10,
  parameter int NEURONS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] input_sel,
  output logic [7:0]  neuron_sel,
  output logic        rst_Acc,
  output logic        ld_Acc,
  output logic        ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_ACT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] C_LAST_INPUT  = 16'(N - 1);
  localparam logic [7:0]  C_LAST_NEURON = 8'(NEURONS - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  nsel_q, nsel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      nsel_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nsel_q  <= nsel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nsel_d  = nsel_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = 16'd0;
        nsel_d = 8'd0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = 16'd0;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (cnt_q == C_LAST_INPUT) begin
          cnt_d   = 16'd0;
          state_d = S_ACT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACT: begin
        // More neurons left in this layer: loop back without visiting IDLE.
        if (nsel_q < C_LAST_NEURON) begin
          nsel_d  = nsel_q + 8'd1;
          state_d = S_CLEAR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        nsel_d  = 8'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 16'd0;
        nsel_d  = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from registered state and counters only.
  assign input_sel  = {16'd0, cnt_q};
  assign neuron_sel = nsel_q;
  assign rst_Acc    = (state_q == S_CLEAR);
  assign ld_Acc     = (state_q == S_ACCUM);
  assign ready      = (state_q == S_ACT);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mac_sequencer: three sequencer configurations vs. a timing model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mac_sequencer;

  localparam int PN   [3] = '{10, 1, 2};
  localparam int PNEU [3] = '{1, 3, 1};

  logic        clk;
  logic [2:0]  rst_v;
  logic [2:0]  start_v;
  logic [31:0] d_isel [3];
  logic [7:0]  d_nsel [3];
  logic [2:0]  d_rac, d_ld, d_rdy, d_busy, d_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;
  bit chk_en  = 0;
  bit mon_en  = 0;
  bit acc_chk = 0;
  int mon     = 0;

  bit m_act [3] = '{0, 0, 0};
  int m_k   [3] = '{0, 0, 0};

  int rdy_c[$], rdy_n[$], done_c[$], clr_c[$];
  int in_mem [16];
  int w_mem  [16];
  int acc = 0;

  mac_sequencer #(.N(10), .NEURONS(1)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
    .input_sel(d_isel[0]), .neuron_sel(d_nsel[0]), .rst_Acc(d_rac[0]),
    .ld_Acc(d_ld[0]), .ready(d_rdy[0]), .busy(d_busy[0]), .done(d_done[0]));

  mac_sequencer #(.N(1), .NEURONS(3)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
    .input_sel(d_isel[1]), .neuron_sel(d_nsel[1]), .rst_Acc(d_rac[1]),
    .ld_Acc(d_ld[1]), .ready(d_rdy[1]), .busy(d_busy[1]), .done(d_done[1]));

  mac_sequencer #(.N(2), .NEURONS(1)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]),
    .input_sel(d_isel[2]), .neuron_sel(d_nsel[2]), .rst_Acc(d_rac[2]),
    .ld_Acc(d_ld[2]), .ready(d_rdy[2]), .busy(d_busy[2]), .done(d_done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs from the layer timeline: k counts cycles since the
  // start edge; each neuron occupies N+2 cycles, DONE follows the last one.
  function automatic logic [44:0] model_out(input int n, input int neu, input bit act, input int k);
    int j, r;
    logic [31:0] isel;
    logic [7:0]  nsel;
    logic        rac, ld, rdy, dn;
    isel = 0; nsel = 0; rac = 0; ld = 0; rdy = 0; dn = 0;
    if (!act) return 45'd0;
    if (k == neu * (n + 2) + 1) begin
      dn   = 1'b1;
      nsel = 8'(neu - 1);
    end else begin
      j    = (k - 1) / (n + 2);
      r    = (k - 1) % (n + 2);
      nsel = 8'(j);
      if (r == 0) rac = 1'b1;
      else if (r <= n) begin
        ld   = 1'b1;
        isel = 32'(r - 1);
      end else rdy = 1'b1;
    end
    return {isel, nsel, rac, ld, rdy, 1'b1, dn};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) m_act[i] <= 1'b0;
      else if (m_act[i]) begin
        if (m_k[i] == PNEU[i] * (PN[i] + 2) + 1) m_act[i] <= 1'b0;
        else m_k[i] <= m_k[i] + 1;
      end else if (start_v[i]) begin
        m_act[i] <= 1'b1;
        m_k[i]   <= 1;
      end
    end
    if (d_rac[0]) acc <= 0;
    else if (d_ld[0]) acc <= acc + in_mem[d_isel[0][3:0]] * w_mem[d_isel[0][3:0]];
  end

  always @(negedge clk) begin
    logic [44:0] e_v, a_v;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        e_v = model_out(PN[i], PNEU[i], m_act[i], m_k[i]);
        a_v = {d_isel[i], d_nsel[i], d_rac[i], d_ld[i], d_rdy[i], d_busy[i], d_done[i]};
        check($sformatf("cycle%0d_dut%0d", cyc, i), 64'(a_v), 64'(e_v));
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (d_rdy[mon]) begin
        rdy_c.push_back(cyc - t0);
        rdy_n.push_back(int'(d_nsel[mon]));
        if (acc_chk) check("acc_result", 64'(acc), 64'd60);
      end
      if (d_done[mon]) done_c.push_back(cyc - t0);
      if (d_rac[mon])  clr_c.push_back(cyc - t0);
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    rdy_c.delete(); rdy_n.delete(); done_c.delete(); clr_c.delete();
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic pulse_start(input int i);
    t0 = cyc;
    start_v[i] = 1'b1;
    step(1);
    start_v[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      in_mem[i] = 2;
      w_mem[i]  = 3;
    end
    rst_v   = 3'b111;
    start_v = 3'b111;
    @(posedge clk);
    #1 chk_en = 1;
    step(1);
    @(negedge clk);
    check("reset_busy", 64'(d_busy), 64'd0);
    check("reset_strobes", 64'({d_rac, d_ld, d_rdy, d_done}), 64'd0);
    step(1);
    rst_v   = 3'b000;
    start_v = 3'b000;
    step(2);

    // Single neuron with a second, ignored start at cycle 5.
    clear_logs(); mon = 0; mon_en = 1; acc_chk = 1;
    pulse_start(0);
    step(4);
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    step(12);
    acc_chk = 0;
    check("n10_ready_count", 64'(rdy_c.size()), 64'd1);
    check("n10_ready_cycle", 64'(qget(rdy_c, 0)), 64'd12);
    check("n10_done_count", 64'(done_c.size()), 64'd1);
    check("n10_done_cycle", 64'(qget(done_c, 0)), 64'd13);
    check("n10_clear_count", 64'(clr_c.size()), 64'd1);

    // N=1, three neurons.
    clear_logs(); mon = 1;
    pulse_start(1);
    step(10);
    @(negedge clk);
    check("n1_nsel_after_done", 64'(d_nsel[1]), 64'd0);
    check("n1_ready0", 64'(qget(rdy_c, 0)), 64'd3);
    check("n1_ready1", 64'(qget(rdy_c, 1)), 64'd6);
    check("n1_ready2", 64'(qget(rdy_c, 2)), 64'd9);
    check("n1_nsel0", 64'(qget(rdy_n, 0)), 64'd0);
    check("n1_nsel1", 64'(qget(rdy_n, 1)), 64'd1);
    check("n1_nsel2", 64'(qget(rdy_n, 2)), 64'd2);
    check("n1_done", 64'(qget(done_c, 0)), 64'd10);
    step(3);

    // Reset in the middle of ACCUM, then a clean restart.
    clear_logs(); mon = 0;
    pulse_start(0);
    step(5);
    rst_v[0] = 1'b1;
    step(1);
    rst_v[0] = 1'b0;
    @(negedge clk);
    check("abort_ld", 64'(d_ld[0]), 64'd0);
    check("abort_isel", 64'(d_isel[0]), 64'd0);
    check("abort_busy", 64'(d_busy[0]), 64'd0);
    step(20);
    check("abort_no_ready", 64'(rdy_c.size()), 64'd0);
    check("abort_no_done", 64'(done_c.size()), 64'd0);
    clear_logs();
    pulse_start(0);
    step(15);
    check("restart_ready", 64'(qget(rdy_c, 0)), 64'd12);
    check("restart_done", 64'(qget(done_c, 0)), 64'd13);

    // Held start on N=2: layers repeat every 6 cycles.
    clear_logs(); mon = 2;
    t0 = cyc;
    start_v[2] = 1'b1;
    step(20);
    start_v[2] = 1'b0;
    check("held_done0", 64'(qget(done_c, 0)), 64'd5);
    check("held_done1", 64'(qget(done_c, 1)), 64'd11);
    check("held_done2", 64'(qget(done_c, 2)), 64'd17);
    check("held_clr0", 64'(qget(clr_c, 0)), 64'd1);
    check("held_clr1", 64'(qget(clr_c, 1)), 64'd7);
    check("held_clr2", 64'(qget(clr_c, 2)), 64'd13);
    check("held_clr3", 64'(qget(clr_c, 3)), 64'd19);
    step(10);
    mon_en = 0;

    // Random start/reset traffic on all three configurations.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        start_v[i] = ($urandom_range(3) == 0);
        rst_v[i]   = ($urandom_range(39) == 0);
      end
      step(1);
    end
    start_v = 3'b000;
    rst_v   = 3'b000;
    step(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
